uart_tx_buffered: RTL and testbench

//  Parametrised UART transmitter with an internal transmit FIFO. Sits between the core's

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 71 +++++++
 rtl/uart_tx_buffered.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the buffered UART transmitter.
//   parity_e    : parity mode (NONE, ODD, EVEN)
//   tx_state_e  : frame sequencer states
//   bit_period  : clocks per bit from clocks per half bit
//   stop_period : shortened final stop bit (90% of a bit period)
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int bit_period(input int half_bit);
        return 2 * half_bit;
    endfunction

    function automatic int stop_period(input int half_bit);
        return (2 * half_bit * 9) / 10;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART sequencer.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push_i   : write wdata_i (ignored while full, even if popping)
//   wdata_i  : word to store
//   pop_i    : drop the head word (ignored while empty)
//   rdata_o  : head word, valid while !empty_o
//   full_o   : DEPTH words stored
//   empty_o  : no words stored
//   count_o  : words stored
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Full blocks a push even when the same edge pops.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO plus frame sequencer with configurable
// data width, parity and stop bits. Frames run back to back while words
// are queued; the final stop bit is shortened to 90% of a bit period.
//   clk        : system clock
//   rst        : synchronous active-high reset, abandons any frame
//   valid_send : producer offers data_send
//   data_send  : word to transmit, LSB first
//   ready_send : FIFO not full (word accepted when valid_send && ready_send)
//   UART_TX    : serial line, idle high
//   fifo_count : queued words, not counting the frame in flight
//   busy       : frame in flight or words queued
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_send,
    input  logic [DATA_BITS-1:0]              data_send,
    output logic                              ready_send,
    output logic                              UART_TX,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy
);

    localparam int      T_CLK    = bit_period(CLK_PER_HALF_BIT);
    localparam int      TS_CLK   = stop_period(CLK_PER_HALF_BIT);
    localparam int      CW       = $clog2(T_CLK);
    localparam int      FCW      = $clog2(FIFO_DEPTH + 1);
    localparam parity_e PAR_MODE = (PARITY == 1) ? ODD : (PARITY == 2) ? EVEN : NONE;

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 fifo_full, fifo_empty, pop, push_ok;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [FCW-1:0]       fifo_cnt, cnt_nxt;
    logic                 last_stop, tick;

    assign push_ok = valid_send && !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .wdata_i (data_send),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // stop_q marks the second stop bit; with one stop bit the first is last.
    assign last_stop = (state_q == ST_STOP) && ((STOP_BITS == 1) || stop_q);
    assign tick      = last_stop ? (baud_q == CW'(TS_CLK - 1))
                                 : (baud_q == CW'(T_CLK - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CW'(1);
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        stop_d  = 1'b0;
                        state_d = (PAR_MODE != NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    baud_d  = '0;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    baud_d = '0;
                    if (last_stop) begin
                        // Chain straight into the next start bit when queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = fifo_rdata;
            par_d   = (PAR_MODE == EVEN) ? ^fifo_rdata : ~^fifo_rdata;
        end

        // Line is registered from the current state, so it trails the
        // sequencer by one clock for the whole frame.
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase

        cnt_nxt = fifo_cnt;
        if (push_ok && !pop)      cnt_nxt = fifo_cnt + FCW'(1);
        else if (!push_ok && pop) cnt_nxt = fifo_cnt - FCW'(1);
        busy_d = (state_d != ST_IDLE) || (cnt_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_send = !fifo_full;
    assign UART_TX    = tx_q;
    assign fifo_count = fifo_cnt;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four instances with T=8/TS=7 covering default
// framing, even parity, odd parity, and 7 data bits with 2 stop bits. A
// queue/waveform model predicts the line, count, ready and busy each cycle.
module tb_uart_tx_buffered;

    localparam int T  = 8;
    localparam int TS = 7;
    localparam int NI = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NI-1:0]        valid;
    logic [NI-1:0][8:0]   data;
    logic [NI-1:0]        tx_w, rdy_w, busy_w;
    logic [NI-1:0][4:0]   cnt_w;

    int nchk = 0;
    int nfail = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB = (g == 3) ? 7 : 8;
        localparam int PB = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        uart_tx_buffered #(
            .CLK_PER_HALF_BIT (4),
            .DATA_BITS        (DB),
            .PARITY           (PB),
            .STOP_BITS        (SB),
            .FIFO_DEPTH       (16)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .valid_send (valid[g]),
            .data_send  (data[g][DB-1:0]),
            .ready_send (rdy_w[g]),
            .UART_TX    (tx_w[g]),
            .fifo_count (cnt_w[g]),
            .busy       (busy_w[g])
        );
    end

    function automatic int cfg_db(int i);  return (i == 3) ? 7 : 8; endfunction
    function automatic int cfg_par(int i); return (i == 1) ? 2 : (i == 2) ? 1 : 0; endfunction
    function automatic int cfg_sb(int i);  return (i == 3) ? 2 : 1; endfunction
    function automatic int flen(int i);
        return T * (1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i) - 1) + TS;
    endfunction

    // Line level at clock p of a frame carrying w on instance i.
    function automatic bit lvl(int i, int p, logic [8:0] w);
        int db, par, j;
        bit x;
        db  = cfg_db(i);
        par = cfg_par(i);
        if (p < T) return 1'b0;
        j = (p - T) / T;
        if (j < db) return w[j];
        if (par != 0 && j == db) begin
            x = 1'b0;
            for (int b = 0; b < db; b++) x ^= w[b];
            return (par == 2) ? x : !x;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc_n);
        end
    endtask

    // Model: queue of accepted words; a frame is a fixed waveform of flen
    // clocks started when a word leaves the queue. The line shows that
    // waveform one clock after the sequencer steps through it.
    int unsigned mq [NI][$];
    bit          inf [NI];
    int          mpos [NI];
    logic [8:0]  mword [NI];
    bit          e_tx [NI];
    int          e_cnt [NI];
    bit          e_rdy [NI];
    bit          e_busy [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit acc;
            int n0;
            if (rst) begin
                mq[i].delete();
                inf[i]  = 1'b0;
                mpos[i] = 0;
                e_tx[i] = 1'b1;
            end else begin
                acc     = valid[i] && (mq[i].size() < 16);
                e_tx[i] = inf[i] ? lvl(i, mpos[i], mword[i]) : 1'b1;
                n0      = mq[i].size();
                if (inf[i] && mpos[i] != flen(i) - 1) begin
                    mpos[i]++;
                end else if (n0 > 0) begin
                    mword[i] = 9'(mq[i].pop_front());
                    inf[i]   = 1'b1;
                    mpos[i]  = 0;
                end else begin
                    inf[i] = 1'b0;
                end
                if (acc) mq[i].push_back(int'(data[i]) & ((1 << cfg_db(i)) - 1));
            end
            e_cnt[i]  = mq[i].size();
            e_rdy[i]  = (mq[i].size() < 16);
            e_busy[i] = inf[i] || (mq[i].size() != 0);
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("tx[%0d]", i),    32'(tx_w[i]),   32'(e_tx[i]));
                chk($sformatf("count[%0d]", i), 32'(cnt_w[i]),  32'(e_cnt[i]));
                chk($sformatf("ready[%0d]", i), 32'(rdy_w[i]),  32'(e_rdy[i]));
                chk($sformatf("busy[%0d]", i),  32'(busy_w[i]), 32'(e_busy[i]));
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc_n < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (busy_w != '0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy_w == '0), 32'd1);
    endtask

    bit rec_tx [NI][100];
    bit rec_busy [NI][100];
    int a5b [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        int n, acc;
        bit quiet;
        rst   = 1'b1;
        valid = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx",    32'(tx_w[0]),   32'd1);
        chk("rst_ready", 32'(rdy_w[0]),  32'd1);
        chk("rst_count", 32'(cnt_w[0]),  32'd0);
        chk("rst_busy",  32'(busy_w[0]), 32'd0);
        @(negedge clk);

        // One frame per instance; instance 3 gets a second word for chaining.
        valid   = '1;
        data[0] = 9'h0A5;
        data[1] = 9'h007;
        data[2] = 9'h007;
        data[3] = 9'h055;
        @(negedge clk);
        n     = cyc_n;
        valid = 4'b1000;
        for (int k = 0; k < 100; k++) begin
            wait_to(n + k);
            if (k == 1) valid = '0;
            for (int i = 0; i < NI; i++) begin
                rec_tx[i][k]   = tx_w[i];
                rec_busy[i][k] = busy_w[i];
            end
        end
        chk("a5_busy_on",   32'(rec_busy[0][0]), 32'd1);
        chk("a5_lat_idle",  32'(rec_tx[0][1]),   32'd1);
        chk("a5_start_b",   32'(rec_tx[0][2]),   32'd0);
        chk("a5_start_e",   32'(rec_tx[0][9]),   32'd0);
        for (int b = 0; b < 8; b++)
            chk($sformatf("a5_bit%0d", b), 32'(rec_tx[0][14 + 8 * b]), 32'(a5b[b]));
        chk("a5_stop",      32'(rec_tx[0][74]),  32'd1);
        chk("a5_busy_last", 32'(rec_busy[0][79]), 32'd1);
        chk("a5_busy_off",  32'(rec_busy[0][80]), 32'd0);
        chk("even_par",     32'(rec_tx[1][78]),  32'd1);
        chk("odd_par",      32'(rec_tx[2][78]),  32'd0);
        chk("par_busy_last",32'(rec_busy[1][87]), 32'd1);
        chk("par_busy_off", 32'(rec_busy[1][88]), 32'd0);
        chk("odd_busy_off", 32'(rec_busy[2][88]), 32'd0);
        chk("d7_bit5",      32'(rec_tx[3][54]),  32'd0);
        chk("d7_stop_b",    32'(rec_tx[3][66]),  32'd1);
        chk("d7_stop_e",    32'(rec_tx[3][80]),  32'd1);
        chk("d7_chain",     32'(rec_tx[3][81]),  32'd0);
        wait_idle(400);

        // Hold valid for 20 clocks on an idle instance.
        @(negedge clk);
        valid[0] = 1'b1;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            data[0] = 9'($urandom_range(0, 511));
            if (rdy_w[0]) acc++;
            @(negedge clk);
        end
        valid[0] = 1'b0;
        chk("fill_accepted", 32'(acc),      32'd17);
        chk("fill_ready",    32'(rdy_w[0]), 32'd0);
        chk("fill_count",    32'(cnt_w[0]), 32'd16);
        wait_idle(2000);

        // Push coinciding with pop at count 1.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h001;
        @(negedge clk);
        n       = cyc_n;
        data[0] = 9'h002;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("pp_idle_pop", 32'(cnt_w[0]), 32'd1);
        wait_to(n + 79);
        valid[0] = 1'b1;
        data[0]  = 9'h003;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("pp_stop_pop", 32'(cnt_w[0]), 32'd1);
        wait_idle(400);

        // Reset during data bit 3 with three words queued.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'($urandom_range(0, 255));
        @(negedge clk);
        n = cyc_n;
        for (int k = 0; k < 3; k++) begin
            data[0] = 9'($urandom_range(0, 255));
            @(negedge clk);
        end
        valid[0] = 1'b0;
        chk("mr_queued", 32'(cnt_w[0]), 32'd3);
        wait_to(n + 35);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_tx",    32'(tx_w[0]),   32'd1);
        chk("mr_count", 32'(cnt_w[0]),  32'd0);
        chk("mr_ready", 32'(rdy_w[0]),  32'd1);
        chk("mr_busy",  32'(busy_w[0]), 32'd0);
        quiet = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) quiet = 1'b0;
        end
        chk("mr_quiet", 32'(quiet), 32'd1);

        // Random traffic with bursts and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NI; i++) begin
                valid[i] = (k >= 1000 && k < 1200) ? 1'b1 : ($urandom_range(0, 7) == 0);
                data[i]  = 9'($urandom_range(0, 511));
            end
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        valid = '0;
        rst   = 1'b0;
        wait_idle(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
